// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus between the access controller and the data RAM.
//   m_req   : request held high for the whole access
//   m_we    : write enable (stable while m_req)
//   m_be    : byte enables (stable while m_req)
//   m_addr  : word-aligned address (stable while m_req)
//   m_wdata : lane-placed store data (stable while m_req)
//   m_rdata : read data, valid together with m_ack
//   m_ack   : one-cycle completion strobe from the RAM
// master = controller side, slave = RAM side.
interface mem_access_ctrl_if;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between the MEM stage and a handshaked RAM.
// Accepts one aligned load/store at a time, holds the RAM bus stable until
// m_ack, captures read data for the 16-bit load-extension stage and stalls
// the pipeline while the access is in flight. Misaligned or conflicting
// requests pulse addr_err_o; an access with no ack for TIMEOUT_CYC busy
// cycles is aborted with a bus_err_o pulse.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   mem_read_i        : load request
//   mem_write_i       : store request
//   half_i            : 1 = halfword access, 0 = word access
//   unsign_i          : zero-extend load
//   addr_i            : byte address
//   wdata_i           : store data (halfword in [15:0])
//   stall_o           : combinational pipeline hold
//   ld_word_o         : last captured read word
//   ld_half_sel_o     : latched addr[1] for half loads, 0 for word loads
//   ld_unsign_o       : latched unsign_i of the load
//   ld_valid_o        : one-cycle pulse, ld_* valid for this load
//   addr_err_o        : one-cycle pulse, misaligned or read+write conflict
//   bus_err_o         : one-cycle pulse, timeout abort
//   bus               : RAM bus (master modport)
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read_i,
    input  logic                     mem_write_i,
    input  logic                     half_i,
    input  logic                     unsign_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              wdata_i,
    output logic                     stall_o,
    output logic [31:0]              ld_word_o,
    output logic                     ld_half_sel_o,
    output logic                     ld_unsign_o,
    output logic                     ld_valid_o,
    output logic                     addr_err_o,
    output logic                     bus_err_o,
    mem_access_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [29:0]       waddr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              half_sel_q;
    logic              unsign_q;
    logic [31:0]       ld_word_q;
    logic              addr_err_q;
    logic              bus_err_q;

    logic              req_any;
    logic              conflict;
    logic              misalign;
    logic              idle_open;
    logic              accept;
    logic              reject;
    logic              timeout;
    logic              capture;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;

    // Request classification
    assign req_any  = mem_read_i | mem_write_i;
    assign conflict = mem_read_i & mem_write_i;
    assign misalign = half_i ? addr_i[0] : (addr_i[1:0] != 2'b00);

    // During the bus_err pulse the aborted access is still on the inputs;
    // let it retire with the error instead of re-issuing it.
    assign idle_open = (state_q == IDLE) && !bus_err_q;
    assign accept    = idle_open && req_any && !conflict && !misalign;
    assign reject    = idle_open && req_any && (conflict || misalign);

    assign timeout = (state_q == BUSY) && !bus.m_ack && (cnt_q == LAST_CNT);
    assign capture = (state_q == BUSY) && bus.m_ack && !we_q;

    // Lane placement: halfword goes to the lane picked by addr[1]; store data
    // is replicated so the RAM only needs the byte enables.
    always_comb begin
        be_d = 4'b1111;
        if (half_i) begin
            be_d = addr_i[1] ? 4'b1100 : 4'b0011;
        end
    end

    assign wdata_d = half_i ? {wdata_i[15:0], wdata_i[15:0]} : wdata_i;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state, timeout counter and stall
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    stall_o = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                // An ack on the last allowed cycle still completes normally.
                if (bus.m_ack) begin
                    state_d = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latched access fields, captured read word and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            half_sel_q <= 1'b0;
            unsign_q   <= 1'b0;
            ld_word_q  <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            addr_err_q <= reject;
            bus_err_q  <= timeout;
            if (accept) begin
                waddr_q <= addr_i[31:2];
                we_q    <= mem_write_i;
                be_q    <= be_d;
                wdata_q <= wdata_d;
                // Load-extension controls only follow loads so a store in
                // between does not disturb what the last load reported.
                if (mem_read_i) begin
                    half_sel_q <= half_i & addr_i[1];
                    unsign_q   <= unsign_i;
                end
            end
            if (capture) begin
                ld_word_q <= bus.m_rdata;
            end
        end
    end

    // RAM bus: m_req follows the state so it drops the moment reset hits.
    assign bus.m_req   = (state_q == BUSY);
    assign bus.m_we    = we_q;
    assign bus.m_be    = be_q;
    assign bus.m_addr  = {waddr_q, 2'b00};
    assign bus.m_wdata = wdata_q;

    // Load-extension side
    assign ld_word_o     = ld_word_q;
    assign ld_half_sel_o = half_sel_q;
    assign ld_unsign_o   = unsign_q;
    assign ld_valid_o    = (state_q == DONE) && !we_q;
    assign addr_err_o    = addr_err_q;
    assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int TO  = 16;
    localparam int WIN = TO + 4;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write, half, unsign_in;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] ld_word;
    logic        ld_half_sel, ld_unsign, ld_valid, addr_err, bus_err;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .half_i        (half),
        .unsign_i      (unsign_in),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .ld_word_o     (ld_word),
        .ld_half_sel_o (ld_half_sel),
        .ld_unsign_o   (ld_unsign),
        .ld_valid_o    (ld_valid),
        .addr_err_o    (addr_err),
        .bus_err_o     (bus_err),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Last word a completed load returned (ld_word must hold it).
    logic [31:0] last_word;

    // Observations of one access window, filled by run_access.
    int          o_busy, o_stall, o_aerr_n, o_aerr_c, o_berr_n, o_berr_c, o_ldv_n, o_ldv_c;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_ldword, o_word_end;
    logic        o_we, o_unstable, o_hsel, o_uns, o_req0;

    // Drives one request as the pipeline would (held while stalled, dropped
    // afterwards), plays the RAM (ack after ackd busy cycles, 0 = never, plus
    // stray acks when no request is out) and records what the DUT did over a
    // fixed window.
    task automatic run_access(input logic rd, input logic wr, input logic hf, input logic un,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input int ackd, input logic [31:0] rdat);
        bit hold;
        o_busy = 0; o_stall = 0; o_aerr_n = 0; o_aerr_c = 0; o_berr_n = 0; o_berr_c = 0;
        o_ldv_n = 0; o_ldv_c = 0; o_be = '0; o_addr = '0; o_wdata = '0; o_ldword = '0;
        o_we = 1'b0; o_unstable = 1'b0; o_hsel = 1'b0; o_uns = 1'b0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; half = hf; unsign_in = un; addr = ad; wdata = wd;
        #1;
        o_stall = stall ? 1 : 0;
        o_req0  = bus.m_req;
        hold    = stall;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            if (!hold) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
            #1;
            if (stall) o_stall++;
            hold = stall;
            if (addr_err) begin o_aerr_n++; o_aerr_c = c; end
            if (bus_err)  begin o_berr_n++; o_berr_c = c; end
            if (ld_valid) begin
                o_ldv_n++; o_ldv_c = c; o_ldword = ld_word; o_hsel = ld_half_sel; o_uns = ld_unsign;
            end
            if (bus.m_req) begin
                o_busy++;
                if (o_busy == 1) begin
                    o_be = bus.m_be; o_addr = bus.m_addr; o_wdata = bus.m_wdata; o_we = bus.m_we;
                end else if (bus.m_be !== o_be || bus.m_addr !== o_addr ||
                             bus.m_wdata !== o_wdata || bus.m_we !== o_we) begin
                    o_unstable = 1'b1;
                end
                if (o_busy == ackd) begin
                    bus.m_ack = 1'b1; bus.m_rdata = rdat;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.m_ack = 1'b1; bus.m_rdata = $urandom;
            end
            @(posedge clk);
            #1;
            bus.m_ack = 1'b0;
        end
        o_word_end = ld_word;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; half = 1'b0; unsign_in = 1'b0;
        addr = '0; wdata = '0; bus.m_ack = 1'b0; bus.m_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req got=%b exp=0", bus.m_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if ({ld_valid, addr_err, bus_err, ld_half_sel, ld_unsign} !== 5'b0) begin
            bad++; $display("FAIL reset_pulses got=%b exp=00000", {ld_valid, addr_err, bus_err, ld_half_sel, ld_unsign});
        end
        total++; if (ld_word !== 32'h0) begin bad++; $display("FAIL reset_ld_word got=%h exp=0", ld_word); end
        total++; if ({bus.m_be, bus.m_addr, bus.m_wdata, bus.m_we} !== 69'h0) begin
            bad++; $display("FAIL reset_bus got=%h/%h/%h/%b exp=0", bus.m_be, bus.m_addr, bus.m_wdata, bus.m_we);
        end
        @(negedge clk);
        rst = 1'b0;
        last_word = 32'h0;
    endtask

    task automatic test_half_load();
        run_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, $urandom, 1, 32'hBEEF_1234);
        total++; if (o_be !== 4'b1100) begin bad++; $display("FAIL hload_be got=%b exp=1100", o_be); end
        total++; if (o_addr !== 32'h100) begin bad++; $display("FAIL hload_addr got=%h exp=100", o_addr); end
        total++; if (o_ldv_n !== 1 || o_ldv_c !== 2) begin
            bad++; $display("FAIL hload_ldv got=%0d@%0d exp=1@2", o_ldv_n, o_ldv_c);
        end
        total++; if (o_ldword !== 32'hBEEF_1234) begin bad++; $display("FAIL hload_word got=%h exp=beef1234", o_ldword); end
        total++; if (o_hsel !== 1'b1 || o_uns !== 1'b1) begin
            bad++; $display("FAIL hload_sel_uns got=%b%b exp=11", o_hsel, o_uns);
        end
        total++; if (o_stall !== 2) begin bad++; $display("FAIL hload_stall got=%0d exp=2", o_stall); end
        last_word = 32'hBEEF_1234;
    endtask

    task automatic test_word_store();
        run_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_BABE, 5, 32'h1111_2222);
        total++; if (o_we !== 1'b1 || o_be !== 4'b1111) begin
            bad++; $display("FAIL wstore_we_be got=%b/%b exp=1/1111", o_we, o_be);
        end
        total++; if (o_wdata !== 32'hCAFE_BABE || o_addr !== 32'h200) begin
            bad++; $display("FAIL wstore_data got=%h@%h exp=cafebabe@200", o_wdata, o_addr);
        end
        total++; if (o_stall !== 6 || o_busy !== 5) begin
            bad++; $display("FAIL wstore_stall got=%0d/%0d exp=6/5", o_stall, o_busy);
        end
        total++; if (o_ldv_n !== 0 || o_word_end !== last_word) begin
            bad++; $display("FAIL wstore_noload got=%0d/%h exp=0/%h", o_ldv_n, o_word_end, last_word);
        end
        total++; if (o_unstable !== 1'b0) begin bad++; $display("FAIL wstore_stable got=%b exp=0", o_unstable); end
    endtask

    task automatic test_half_store();
        run_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_A5A5, 2, $urandom);
        total++; if (o_be !== 4'b0011) begin bad++; $display("FAIL hstore_be got=%b exp=0011", o_be); end
        total++; if (o_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL hstore_wdata got=%h exp=a5a5a5a5", o_wdata); end
    endtask

    task automatic test_addr_err();
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0006, $urandom, 1, $urandom);
        total++; if (o_aerr_n !== 1 || o_aerr_c !== 1) begin
            bad++; $display("FAIL misalign_err got=%0d@%0d exp=1@1", o_aerr_n, o_aerr_c);
        end
        total++; if (o_req0 !== 1'b0 || o_busy !== 0 || o_stall !== 0) begin
            bad++; $display("FAIL misalign_noaccess got=%b/%0d/%0d exp=0/0/0", o_req0, o_busy, o_stall);
        end
        run_access(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, $urandom, 1, $urandom);
        total++; if (o_aerr_n !== 1 || o_busy !== 0) begin
            bad++; $display("FAIL conflict_err got=%0d/%0d exp=1/0", o_aerr_n, o_busy);
        end
        run_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0013, $urandom, 1, $urandom);
        total++; if (o_aerr_n !== 1 || o_busy !== 0) begin
            bad++; $display("FAIL odd_half_err got=%0d/%0d exp=1/0", o_aerr_n, o_busy);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0800, $urandom, 0, $urandom);
        total++; if (o_berr_n !== 1 || o_berr_c !== TO + 1) begin
            bad++; $display("FAIL timeout_berr got=%0d@%0d exp=1@%0d", o_berr_n, o_berr_c, TO + 1);
        end
        total++; if (o_busy !== TO || o_stall !== TO + 1 || o_ldv_n !== 0) begin
            bad++; $display("FAIL timeout_shape got=%0d/%0d/%0d exp=%0d/%0d/0", o_busy, o_stall, o_ldv_n, TO, TO + 1);
        end
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0804, $urandom, TO, 32'h5A5A_0F0F);
        total++; if (o_berr_n !== 0 || o_ldv_n !== 1 || o_ldv_c !== TO + 1) begin
            bad++; $display("FAIL lastack got=berr%0d ldv%0d@%0d exp=berr0 ldv1@%0d", o_berr_n, o_ldv_n, o_ldv_c, TO + 1);
        end
        total++; if (o_ldword !== 32'h5A5A_0F0F) begin bad++; $display("FAIL lastack_word got=%h exp=5a5a0f0f", o_ldword); end
        last_word = 32'h5A5A_0F0F;
    endtask

    // Random traffic against a transaction-level model: each request is
    // either rejected, completes after its ack delay, or times out.
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic rd, wr, hf, un, bad_req, done;
            logic [31:0] ad, wd, rdat, exp_wd;
            logic [3:0] exp_be, lane;
            int ackd, n, op;
            op = $urandom_range(0, 9);
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            hf = $urandom_range(0, 1);
            un = $urandom_range(0, 1);
            ad = $urandom; wd = $urandom; rdat = $urandom;
            if ($urandom_range(0, 4) != 0) ad = hf ? (ad & ~32'h1) : (ad & ~32'h3);
            ackd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 4);
            run_access(rd, wr, hf, un, ad, wd, ackd, rdat);

            bad_req = (rd && wr) || (hf ? (ad % 2 != 0) : (ad % 4 != 0));
            done    = (ackd >= 1) && (ackd <= TO);
            n       = done ? ackd : TO;
            lane    = 4'b0011;
            exp_be  = hf ? (lane << (2 * ((ad / 2) % 2))) : 4'b1111;
            exp_wd  = hf ? ((wd % 65536) * 32'h0001_0001) : wd;

            if (bad_req) begin
                total++; if (o_aerr_n !== 1 || o_aerr_c !== 1 || o_busy !== 0 || o_stall !== 0 || o_ldv_n !== 0 || o_berr_n !== 0) begin
                    bad++; $display("FAIL rnd%0d_reject got=aerr%0d@%0d busy%0d stall%0d ldv%0d berr%0d", it, o_aerr_n, o_aerr_c, o_busy, o_stall, o_ldv_n, o_berr_n);
                end
            end else begin
                total++; if (o_busy !== n || o_stall !== n + 1 || o_aerr_n !== 0) begin
                    bad++; $display("FAIL rnd%0d_timing got=busy%0d stall%0d aerr%0d exp=busy%0d stall%0d aerr0", it, o_busy, o_stall, o_aerr_n, n, n + 1);
                end
                total++; if (o_be !== exp_be || o_addr !== {ad[31:2], 2'b00} || o_we !== wr || o_wdata !== exp_wd || o_unstable !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_bus got=%b/%h/%b/%h/%b exp=%b/%h/%b/%h/0", it, o_be, o_addr, o_we, o_wdata, o_unstable, exp_be, {ad[31:2], 2'b00}, wr, exp_wd);
                end
                total++; if (o_ldv_n !== ((done && rd) ? 1 : 0) || o_berr_n !== (done ? 0 : 1)) begin
                    bad++; $display("FAIL rnd%0d_outcome got=ldv%0d berr%0d exp=ldv%0d berr%0d", it, o_ldv_n, o_berr_n, (done && rd) ? 1 : 0, done ? 0 : 1);
                end
                if (done && rd) begin
                    total++; if (o_ldv_c !== n + 1 || o_ldword !== rdat || o_hsel !== (hf && ad[1]) || o_uns !== un) begin
                        bad++; $display("FAIL rnd%0d_load got=%0d/%h/%b/%b exp=%0d/%h/%b/%b", it, o_ldv_c, o_ldword, o_hsel, o_uns, n + 1, rdat, hf && ad[1], un);
                    end
                    last_word = rdat;
                end
                if (!done) begin
                    total++; if (o_berr_c !== n + 1) begin
                        bad++; $display("FAIL rnd%0d_berr_cyc got=%0d exp=%0d", it, o_berr_c, n + 1);
                    end
                end
            end
            total++; if (o_word_end !== last_word) begin
                bad++; $display("FAIL rnd%0d_hold got=%h exp=%h", it, o_word_end, last_word);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int ldv_n;
        ldv_n = 0;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; half = 1'b0; addr = 32'h0000_0300;
        @(negedge clk);
        #1;
        total++; if (bus.m_req !== 1'b1) begin bad++; $display("FAIL rstbusy_pre got=%b exp=1", bus.m_req); end
        rst = 1'b1;
        mem_read = 1'b0;
        #1;
        total++; if (bus.m_req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL rstbusy_drop got=%b/%b exp=0/0", bus.m_req, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        last_word = 32'h0;
        @(negedge clk);
        bus.m_ack = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.m_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (ld_valid || bus.m_req) ldv_n++;
        end
        total++; if (ldv_n !== 0 || ld_word !== 32'h0) begin
            bad++; $display("FAIL rstbusy_lateack got=%0d/%h exp=0/0", ldv_n, ld_word);
        end
    endtask

    initial begin
        test_reset();
        test_half_load();
        test_word_store();
        test_half_store();
        test_addr_err();
        test_timeout();
        test_random();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard ceiling so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
